time_keeper: RTL and testbench
==============================

# time_keeper

Running time-of-day core that sits downstream of the time-setting block. It accepts the hours/minutes/seconds values that block produces, loads them on request, and then advances them once per second from a prescaled system clock. It presents the current time to the display path and flags day rollover. It is the consumer/reader end of the H_IN/M_IN/S_IN set-time interface.

## Interface
Parameters:
- TICKS_PER_SEC, default 100_000_000: clk cycles per second; must be ≥ 2; benches use 4.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- load  in  1  single-cycle strobe: capture H_IN/M_IN/S_IN
- H_IN  in  5  hours to load, legal 0–23
- M_IN  in  6  minutes to load, legal 0–59
- S_IN  in  6  seconds to load, legal 0–59
- run  in  1  1 = time advances; 0 = frozen (prescaler held)
- H_OUT  out  5  current hours
- M_OUT  out  6  current minutes
- S_OUT  out  6  current seconds
- sec_tick  out  1  one-cycle pulse each time seconds advance
- day_wrap  out  1  one-cycle pulse on 23:59:59 → 00:00:00
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset (reset == 0 at a clk edge): H/M/S_OUT = 0, prescaler = 0, sec_tick = day_wrap = load_err = 0.
- Prescaler counts 0..TICKS_PER_SEC-1 while run = 1. Terminal count produces an internal advance and wraps to 0. When run = 0, the prescaler holds its value.
- Advance rules:
  - S increments; 59 → 0 with carry into M.
  - M increments; 59 → 0 with carry into H.
  - H increments; 23 → 0 and asserts day_wrap.
  - All arithmetic stays within the field widths; no intermediate overflow is visible.
- Load handling:
  - If H_IN ≤ 23, M_IN ≤ 59 and S_IN ≤ 59, all three fields are replaced atomically and the prescaler is cleared to 0.
  - If any field is out of range, nothing changes, load_err pulses, and the prescaler keeps counting.
- Priority order: reset > load > advance.
  - An accepted load in the same cycle as terminal count suppresses that advance; no sec_tick and no day_wrap are issued.
  - A rejected load in the same cycle as terminal count: the advance proceeds normally and load_err also pulses.
- load is honoured regardless of run.
- load held high for several cycles re-loads every cycle. Each accepted load clears the prescaler, so time does not advance while load is held.
- Reset asserted mid-count or mid-load wins unconditionally; no pulse outputs fire in that cycle.

## Timing
- All outputs are registered.
- Loaded values appear on H/M/S_OUT at the first clk edge after load is sampled high (latency 1).
- sec_tick and day_wrap are asserted in the same cycle the new time is visible on the outputs.
- After an accepted load or reset release, the first advance occurs exactly TICKS_PER_SEC run-enabled cycles later.
- load_err is asserted the cycle after the rejected load is sampled.
- Steady state: one sec_tick every TICKS_PER_SEC cycles with run = 1; the period is exact and has no drift.

## Structure
- Shared package clock_pkg holds:
  - HOUR_W = 5 and MIN_W = SEC_W = 6
  - HOUR_MAX = 23, MIN_MAX = 59, SEC_MAX = 59
  - a time struct (hours, minutes, seconds), shared with the set-time block and the display driver
- One sub-module, mod_n_counter (parameters N and W; ports inc, ld, ld_val, q, carry), instantiated three times for S, M and H. The carry of each stage gates inc of the next stage.
- The prescaler and load validation live in time_keeper itself.

## Test plan
- Reset: hold reset = 0 for 5 cycles with load = 1, H_IN = 7 → outputs 00:00:00; no pulse outputs at any time.
- Load and count (TICKS_PER_SEC = 4, run = 1): load 12:34:56 → outputs 12:34:56 next cycle, then 12:34:57 four cycles later with sec_tick; after 4 more ticks, 12:35:01.
- Day wrap: load 23:59:58 → after 8 cycles outputs 00:00:00; day_wrap pulses exactly once, coincident with sec_tick.
- Rejection: with time 10:00:00, load H_IN = 24 (then separately M_IN = 60, then S_IN = 63) → time is unchanged, load_err pulses once per attempt, and sec_tick cadence is undisturbed.
- Collision: load 05:05:05 in the terminal-count cycle → outputs 05:05:05 with no sec_tick; next advance arrives 4 cycles later.
- Freeze: run = 0 for 10 cycles mid-count → outputs stable and no sec_tick; after run = 1, the remaining prescaler count completes before the next tick.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day definitions used by the set-time block, the time keeper
// and the display driver.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } time_t;

  // True when every field of t is a legal time-of-day value.
  function automatic logic time_valid(input time_t t);
    return (t.hours   <= HOUR_W'(HOUR_MAX)) &&
           (t.minutes <= MIN_W'(MIN_MAX))   &&
           (t.seconds <= SEC_W'(SEC_MAX));
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with synchronous load; carry is high when inc arrives on
// the last value, so stages chain by feeding carry into the next inc.
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign carry = inc && (q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= carry ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Running time-of-day core: loads H/M/S from the set-time block and advances
// once per TICKS_PER_SEC enabled clock cycles.
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOUR_W-1:0] H_IN,
  input  logic [MIN_W-1:0]  M_IN,
  input  logic [SEC_W-1:0]  S_IN,
  input  logic              run,
  output logic [HOUR_W-1:0] H_OUT,
  output logic [MIN_W-1:0]  M_OUT,
  output logic [SEC_W-1:0]  S_OUT,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              load_err
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  // Set-time interface: load is a one-cycle strobe with no back-pressure; the
  // H_IN/M_IN/S_IN values are only meaningful in the cycle load is high, and
  // every strobe is answered either by a load or by a load_err pulse.
  time_t         set_val;
  time_t         cur;
  logic [PW-1:0] presc;
  logic          terminal;
  logic          accept;
  logic          reject;
  logic          advance;
  logic          s_carry;
  logic          m_carry;
  logic          h_carry;

  assign set_val  = '{hours: H_IN, minutes: M_IN, seconds: S_IN};
  assign terminal = run && (presc == TERM);
  assign accept   = load && time_valid(set_val);
  assign reject   = load && !time_valid(set_val);
  // An accepted load restarts the second, so it swallows a coincident advance.
  assign advance  = terminal && !accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (accept) begin
        presc <= '0;
      end else if (run) begin
        presc <= terminal ? '0 : presc + PW'(1);
      end
      sec_tick <= advance;
      day_wrap <= h_carry;
      load_err <= reject;
    end
  end

  mod_n_counter #(.N(SEC_MAX + 1), .W(SEC_W)) u_sec (
    .clk    (clk),
    .reset  (reset),
    .inc    (advance),
    .ld     (accept),
    .ld_val (set_val.seconds),
    .q      (cur.seconds),
    .carry  (s_carry)
  );

  mod_n_counter #(.N(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clk    (clk),
    .reset  (reset),
    .inc    (s_carry),
    .ld     (accept),
    .ld_val (set_val.minutes),
    .q      (cur.minutes),
    .carry  (m_carry)
  );

  mod_n_counter #(.N(HOUR_MAX + 1), .W(HOUR_W)) u_hour (
    .clk    (clk),
    .reset  (reset),
    .inc    (m_carry),
    .ld     (accept),
    .ld_val (set_val.hours),
    .q      (cur.hours),
    .carry  (h_carry)
  );

  assign H_OUT = cur.hours;
  assign M_OUT = cur.minutes;
  assign S_OUT = cur.seconds;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a seconds-of-day model checked every cycle,
// plus hand-computed checkpoints along the test plan.
module tb_time_keeper;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [4:0] H_IN;
  logic [5:0] M_IN;
  logic [5:0] S_IN;
  logic       run;
  logic [4:0] H_OUT;
  logic [5:0] M_OUT;
  logic [5:0] S_OUT;
  logic       sec_tick;
  logic       day_wrap;
  logic       load_err;

  int vectors = 0;
  int miscompares = 0;

  // Model: time as seconds since midnight plus a count of enabled cycles.
  int  m_secs = 0;
  int  m_pc = 0;
  bit  m_tick = 0;
  bit  m_wrap = 0;
  bit  m_err = 0;
  bit  m_live = 0;
  int  tick_count = 0;
  int  wrap_count = 0;

  time_keeper #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .H_IN     (H_IN),
    .M_IN     (M_IN),
    .S_IN     (S_IN),
    .run      (run),
    .H_OUT    (H_OUT),
    .M_OUT    (M_OUT),
    .S_OUT    (S_OUT),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_tick = 0;
    m_wrap = 0;
    m_err  = 0;
    if (!reset) begin
      m_secs = 0;
      m_pc   = 0;
    end else if (load && H_IN <= 23 && M_IN <= 59 && S_IN <= 59) begin
      m_secs = H_IN * 3600 + M_IN * 60 + S_IN;
      m_pc   = 0;
    end else begin
      m_err = load;
      if (run) begin
        m_pc = m_pc + 1;
        if (m_pc == T) begin
          m_pc   = 0;
          m_secs = (m_secs + 1) % 86400;
          m_tick = 1;
          m_wrap = (m_secs == 0);
        end
      end
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      vectors++;
      if (H_OUT !== 5'(m_secs / 3600) || M_OUT !== 6'((m_secs / 60) % 60) ||
          S_OUT !== 6'(m_secs % 60) || sec_tick !== m_tick ||
          day_wrap !== m_wrap || load_err !== m_err) begin
        miscompares++;
        $display("FAIL model t=%0t got %0d:%0d:%0d tick=%b wrap=%b err=%b exp %0d:%0d:%0d tick=%b wrap=%b err=%b",
                 $time, H_OUT, M_OUT, S_OUT, sec_tick, day_wrap, load_err,
                 m_secs / 3600, (m_secs / 60) % 60, m_secs % 60, m_tick, m_wrap, m_err);
      end
      if (sec_tick === 1'b1) tick_count++;
      if (day_wrap === 1'b1) wrap_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_load(input int h, input int m, input int s);
    load = 1'b1;
    H_IN = 5'(h);
    M_IN = 6'(m);
    S_IN = 6'(s);
  endtask

  task automatic check_lit(input string name, input int h, input int m, input int s,
                           input bit tk, input bit wr, input bit er);
    vectors++;
    if (H_OUT !== 5'(h) || M_OUT !== 6'(m) || S_OUT !== 6'(s) ||
        sec_tick !== tk || day_wrap !== wr || load_err !== er) begin
      miscompares++;
      $display("FAIL %s got %0d:%0d:%0d tick=%b wrap=%b err=%b need %0d:%0d:%0d tick=%b wrap=%b err=%b",
               name, H_OUT, M_OUT, S_OUT, sec_tick, day_wrap, load_err, h, m, s, tk, wr, er);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int need);
    vectors++;
    if (got != need) begin
      miscompares++;
      $display("FAIL %s got %0d need %0d", name, got, need);
    end
  endtask

  int ticks_before;

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    set_load(7, 0, 0);
    step(5);
    check_lit("reset", 0, 0, 0, 0, 0, 0);
    check_cnt("reset_pulses", tick_count + wrap_count, 0);

    // Release reset with a load of 12:34:56 and run enabled.
    reset = 1'b1;
    run   = 1'b1;
    set_load(12, 34, 56);
    step(1);
    load = 1'b0;
    check_lit("load_1234_56", 12, 34, 56, 0, 0, 0);
    step(4);
    check_lit("first_tick", 12, 34, 57, 1, 0, 0);
    step(16);
    check_lit("after_4_ticks", 12, 35, 1, 1, 0, 0);

    // Day wrap.
    set_load(23, 59, 58);
    step(1);
    load = 1'b0;
    wrap_count = 0;
    check_lit("load_235958", 23, 59, 58, 0, 0, 0);
    step(4);
    check_lit("pre_wrap", 23, 59, 59, 1, 0, 0);
    step(4);
    check_lit("day_wrap", 0, 0, 0, 1, 1, 0);
    step(6);
    check_cnt("wrap_once", wrap_count, 1);

    // Rejections; the last one lands on the terminal-count edge.
    set_load(10, 0, 0);
    step(1);
    load = 1'b0;
    step(1);
    set_load(24, 0, 0);
    step(1);
    check_lit("rej_hour", 10, 0, 0, 0, 0, 1);
    set_load(10, 60, 0);
    step(1);
    check_lit("rej_min", 10, 0, 0, 0, 0, 1);
    set_load(10, 0, 63);
    step(1);
    load = 1'b0;
    check_lit("rej_sec_tick", 10, 0, 1, 1, 0, 1);

    // Accepted load on the terminal-count edge swallows the advance.
    step(3);
    set_load(5, 5, 5);
    step(1);
    load = 1'b0;
    check_lit("collision", 5, 5, 5, 0, 0, 0);
    step(3);
    check_lit("collision_wait", 5, 5, 5, 0, 0, 0);
    step(1);
    check_lit("collision_next", 5, 5, 6, 1, 0, 0);

    // Freeze with prescaler at 2, then resume.
    step(2);
    run = 1'b0;
    ticks_before = tick_count;
    step(10);
    check_lit("frozen", 5, 5, 6, 0, 0, 0);
    check_cnt("frozen_ticks", tick_count - ticks_before, 0);
    run = 1'b1;
    step(1);
    check_lit("resume_1", 5, 5, 6, 0, 0, 0);
    step(1);
    check_lit("resume_tick", 5, 5, 7, 1, 0, 0);

    // Load honoured while frozen.
    run = 1'b0;
    set_load(1, 2, 3);
    step(1);
    load = 1'b0;
    check_lit("load_frozen", 1, 2, 3, 0, 0, 0);
    run = 1'b1;
    step(4);
    check_lit("tick_after_frozen_load", 1, 2, 4, 1, 0, 0);

    // Held load re-loads every cycle, so time never advances.
    set_load(2, 0, 0);
    step(9);
    check_lit("held_load", 2, 0, 0, 0, 0, 0);
    load = 1'b0;

    // Reset mid-count with a load pending wins.
    step(2);
    reset = 1'b0;
    set_load(9, 9, 9);
    step(1);
    check_lit("reset_midcount", 0, 0, 0, 0, 0, 0);
    load  = 1'b0;
    reset = 1'b1;
    step(4);
    check_lit("tick_after_reset", 0, 0, 1, 1, 0, 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
